if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC, selects the next PC (sequential, branch, jump), and runs a request/acknowledge fetch FSM against instruction memory. It presents `instr`, `imm_ifu` and `pcplus4F` to IF/ID, and raises `fetch_busy` so the hazard unit can bubble decode while a fetch is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stallF`  in  1  hazard-unit stall; holds the PC and suppresses advance and redirect.
- `pcsrcD`  in  1  branch taken, resolved in decode.
- `branch_target`  in  32  branch destination.
- `jumpD`  in  1  jump in decode.
- `jump_target`  in  32  jump destination.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals the word-aligned PC being fetched.
- `imem_ack`  in  1  data valid; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `pcF`  out  32  PC of the instruction in `instr`.
- `pcplus4F`  out  32  `pcF + 4`, modulo 2^32.
- `instr`  out  32  fetched instruction, registered.
- `imm_ifu`  out  16  `instr[15:0]`, registered alongside `instr`.
- `fetch_busy`  out  1  high when `instr` is not a valid instruction for `pcF`.

## Operation
- FSM states: IDLE, FETCH, READY, DRAIN.
  - IDLE: entered on reset. Next edge goes to FETCH.
  - FETCH: `imem_req`=1 and `imem_addr`=`pcF`. On `imem_ack`: capture `imem_rdata` into `instr`/`imm_ifu` and go to READY. A redirect without ack latches the target into `redir_pc` and goes to DRAIN.
  - DRAIN: `imem_req` stays 1 with the old address held stable. On `imem_ack`: discard the data, set `pcF`=`redir_pc`, go to FETCH. A newer redirect in DRAIN overwrites `redir_pc`.
  - READY: `imem_req`=0.
    - `stallF`=1: hold everything.
    - `stallF`=0 with a redirect: `pcF`=target, go to FETCH.
    - `stallF`=0 without a redirect: `pcF`=`pcF`+4, go to FETCH.
- Redirect definition: `jumpD`, or `pcsrcD`, sampled only when `stallF`=0.
  - `jumpD` has priority over `pcsrcD` when both are high.
  - Target bits [1:0] are forced to 0.
- `stallF` in FETCH or DRAIN does not abort the transaction. The response is still captured in FETCH, or discarded in DRAIN.
- `fetch_busy` = (state != READY).
  - The hazard unit clears IF/ID when `fetch_busy`=1 and decode is not stalled.
  - IF/ID captures `instr` at the same edge the PC advances out of READY.
- `pcplus4F` is always derived from the registered `pcF`. It wraps: 32'hFFFF_FFFC → 32'h0000_0000.
- `imem_ack` is ignored while `imem_req`=0.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state=IDLE, `pcF`=`RESET_PC`, `pcplus4F`=`RESET_PC`+4
  - `instr`=0, `imm_ifu`=0, `redir_pc`=0
  - `imem_req`=0, `fetch_busy`=1
- First request is issued in the 2nd cycle after `rst_n` rises (IDLE lasts 1 cycle).
- Zero-wait memory (ack in the request cycle): FETCH 1 cycle, then READY. Peak throughput is 1 instruction per 2 cycles.
- N-cycle ack latency: FETCH lasts N+1 cycles, and `imem_addr` is stable for all of them.
- Redirect in FETCH with ack in the same cycle: the fetched data is wrong-path.
  - Discard it and go directly to FETCH at the target, with `pcF`=target at the next edge.
  - DRAIN is skipped.
- Reset asserted mid-transaction: return to IDLE immediately. Any later ack is ignored because `imem_req`=0.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `pcF`=0x3000, `pcplus4F`=0x3004, `instr`=0, `imem_req`=0, `fetch_busy`=1. After release: `imem_req`=1 with `imem_addr`=0x3000 in the 2nd cycle.
- Straight line, zero-wait memory returning 0x2008_0005, 0x2009_0007 → READY shows `instr`=0x2008_0005, `imm_ifu`=0x0005, `pcF`=0x3000. Then `imem_addr`=0x3004 and `instr`=0x2009_0007.
- 3-cycle ack latency with `stallF`=1 for 2 cycles in READY → `imem_addr` stable for 4 cycles. `instr` and `pcF` hold through the stall, and the next fetch is at 0x3004 after `stallF` falls.
- Branch in READY: `pcsrcD`=1, `branch_target`=0x3041 → next `imem_addr`=0x3040 and `fetch_busy`=1 for one cycle (zero-wait).
- Redirect during a 2-cycle-latency fetch at 0x3008: `jumpD`=1 to 0x4000 while `pcsrcD`=1 to 0x5000 → DRAIN. The ack data is discarded (`instr` unchanged), then `imem_addr`=0x4000.
- Wrap: `RESET_PC`=32'hFFFF_FFFC → `pcplus4F`=0. After advancing from READY with `stallF`=0, the next `imem_addr`=0x0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, picks the next PC
// (sequential / branch / jump) and runs a req/ack handshake with imem.
// Redirects that arrive while a request is in flight are parked in
// redir_pc_q until the outstanding response is drained.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        pcsrcD,
  input  logic [31:0] branch_target,
  input  logic        jumpD,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F,
  output logic [31:0] instr,
  output logic [15:0] imm_ifu,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {IDLE, FETCH, READY, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] redir_q, redir_d;

  logic        redirect;
  logic [31:0] target;

  // Redirect is only honoured when fetch is not stalled; jump beats branch.
  assign redirect = ~stallF & (jumpD | pcsrcD);
  assign target   = (jumpD ? jump_target : branch_target) & 32'hFFFF_FFFC;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      redir_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      redir_q <= redir_d;
    end
  end

  // Next-state, next-PC and request generation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    redir_d  = redir_q;
    imem_req = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && redirect) begin
          // wrong-path data: drop it and refetch at the target right away
          pc_d = target;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = READY;
        end else if (redirect) begin
          redir_d = target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // keep the old request alive until memory answers, then discard
        imem_req = 1'b1;
        if (redirect) redir_d = target;
        if (imem_ack) begin
          pc_d    = redirect ? target : redir_q;
          state_d = FETCH;
        end
      end
      READY: begin
        if (!stallF) begin
          pc_d    = redirect ? target : pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr  = pc_q;
  assign pcF        = pc_q;
  assign pcplus4F   = pc_q + 32'd4;
  assign instr      = instr_q;
  assign imm_ifu    = instr_q[15:0];
  assign fetch_busy = (state_q != READY);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a latency-programmable imem responder,
// plus a second instance reset at the top of the address space.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, pcsrcD, jumpD;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pcF, pcplus4F, instr;
  logic [15:0] imm_ifu;
  logic        fetch_busy;

  logic        req_w;
  logic [31:0] addr_w, pcF_w, pc4_w, instr_w;
  logic [15:0] imm_w;
  logic        busy_w;

  int          nvec = 0;
  int          nerr = 0;
  logic [3:0]  lat;
  logic [3:0]  wcnt;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .pcsrcD(pcsrcD),
    .branch_target(branch_target), .jumpD(jumpD), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pcF(pcF), .pcplus4F(pcplus4F), .instr(instr),
    .imm_ifu(imm_ifu), .fetch_busy(fetch_busy)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .pcsrcD(pcsrcD),
    .branch_target(branch_target), .jumpD(jumpD), .jump_target(jump_target),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(req_w),
    .imem_rdata(32'h0), .pcF(pcF_w), .pcplus4F(pc4_w), .instr(instr_w),
    .imm_ifu(imm_w), .fetch_busy(busy_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: mem_word = 32'h2008_0005;
      32'h0000_3004: mem_word = 32'h2009_0007;
      default:       mem_word = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  // memory answers after `lat` wait cycles of an asserted request
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 4'd0;
    else                       wcnt <= wcnt + 4'd1;
  end
  assign imem_ack   = imem_req && (wcnt == lat);
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; lat = 4'd0; wcnt = 4'd0;
    stallF = 1'($urandom); pcsrcD = 1'($urandom); jumpD = 1'($urandom);
    branch_target = $urandom; jump_target = $urandom;
    nxt; nxt; nxt;
    chk("rst_pcF",    pcF, 32'h3000);
    chk("rst_pc4",    pcplus4F, 32'h3004);
    chk("rst_instr",  instr, 32'h0);
    chk("rst_imm",    {16'h0, imm_ifu}, 32'h0);
    chk("rst_req",    {31'h0, imem_req}, 32'h0);
    chk("rst_busy",   {31'h0, fetch_busy}, 32'h1);
    chk("rst_w_pc",   pcF_w, 32'hFFFF_FFFC);
    chk("rst_w_pc4",  pc4_w, 32'h0);
    stallF = 0; pcsrcD = 0; jumpD = 0; branch_target = 0; jump_target = 0;
    rst_n = 1'b1;

    // IDLE for one cycle, then first request
    nxt;
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h3000);
    nxt;
    chk("r1_instr",   instr, 32'h2008_0005);
    chk("r1_imm",     {16'h0, imm_ifu}, 32'h0005);
    chk("r1_pcF",     pcF, 32'h3000);
    chk("r1_busy",    {31'h0, fetch_busy}, 32'h0);
    chk("r1_req",     {31'h0, imem_req}, 32'h0);
    chk("w_ready_pc4", pc4_w, 32'h0);
    nxt;
    chk("f2_addr",    imem_addr, 32'h3004);
    chk("w_wrap_addr", addr_w, 32'h0);
    chk("w_wrap_req", {31'h0, req_w}, 32'h1);
    nxt;
    chk("r2_instr",   instr, 32'h2009_0007);
    chk("r2_pcF",     pcF, 32'h3004);
    chk("r2_pc4",     pcplus4F, 32'h3008);

    // branch taken in READY, low bits of target dropped
    pcsrcD = 1; branch_target = 32'h3041;
    nxt;
    pcsrcD = 0;
    chk("br_addr",    imem_addr, 32'h3040);
    chk("br_busy",    {31'h0, fetch_busy}, 32'h1);
    nxt;
    chk("br_busy_lo", {31'h0, fetch_busy}, 32'h0);
    chk("br_instr",   instr, 32'hDEAD_3040);

    // 3-cycle latency: address held for four cycles
    lat = 4'd3;
    for (int i = 0; i < 4; i++) begin
      nxt;
      chk("lat_addr", imem_addr, 32'h3044);
      chk("lat_req",  {31'h0, imem_req}, 32'h1);
    end
    nxt;
    chk("lat_instr", instr, 32'hDEAD_3044);
    // stall READY for two cycles; a stalled branch must be ignored
    stallF = 1; pcsrcD = 1; branch_target = 32'h9000;
    nxt;
    chk("stl1_pcF",  pcF, 32'h3044);
    chk("stl1_busy", {31'h0, fetch_busy}, 32'h0);
    nxt;
    chk("stl2_pcF",   pcF, 32'h3044);
    chk("stl2_instr", instr, 32'hDEAD_3044);
    chk("stl2_req",   {31'h0, imem_req}, 32'h0);
    stallF = 0; pcsrcD = 0; lat = 4'd2;
    nxt;
    chk("post_stl_addr", imem_addr, 32'h3048);

    // jump and branch together while the fetch is pending -> DRAIN
    jumpD = 1; jump_target = 32'h4000; pcsrcD = 1; branch_target = 32'h5000;
    nxt;
    jumpD = 0; pcsrcD = 0;
    chk("drn_req",  {31'h0, imem_req}, 32'h1);
    chk("drn_addr", imem_addr, 32'h3048);
    nxt;
    chk("drn_addr2", imem_addr, 32'h3048);
    nxt;
    chk("redir_addr",  imem_addr, 32'h4000);
    chk("redir_instr", instr, 32'hDEAD_3044);
    nxt; nxt; nxt;
    chk("redir_rdy_instr", instr, 32'hDEAD_4000);
    chk("redir_rdy_pcF",   pcF, 32'h4000);

    // redirect with ack in the same FETCH cycle skips DRAIN
    lat = 4'd0;
    nxt;
    chk("sc_addr", imem_addr, 32'h4004);
    jumpD = 1; jump_target = 32'h5003;
    nxt;
    jumpD = 0;
    chk("sc_addr2", imem_addr, 32'h5000);
    chk("sc_busy",  {31'h0, fetch_busy}, 32'h1);
    chk("sc_instr", instr, 32'hDEAD_4000);
    nxt;
    chk("sc_rdy_instr", instr, 32'hDEAD_5000);

    // asynchronous reset in the middle of a fetch
    nxt;
    chk("mid_addr", imem_addr, 32'h5004);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pcF", pcF, 32'h3000);
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_busy", {31'h0, fetch_busy}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
